// File: rtl/vcve2_vlsu_sequencer_if.sv
// rtl/vcve2_vlsu_sequencer_if.sv - LSU request/response and VRF access bundle for the vector LSU sequencer
interface vcve2_vlsu_sequencer_if #(
  parameter int CNT_W = 6
);
  logic             lsu_req_o;
  logic             lsu_we_o;
  logic [31:0]      lsu_addr_o;
  logic [31:0]      lsu_wdata_o;
  logic             lsu_gnt_i;
  logic             lsu_rvalid_i;
  logic [31:0]      lsu_rdata_i;
  logic             lsu_err_i;
  logic [CNT_W-2:0] vrf_raddr_o;
  logic [31:0]      vrf_rdata_i;
  logic             vrf_we_o;
  logic [CNT_W-2:0] vrf_waddr_o;
  logic [31:0]      vrf_wdata_o;

  modport master (
    output lsu_req_o, lsu_we_o, lsu_addr_o, lsu_wdata_o,
    input  lsu_gnt_i, lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    output vrf_raddr_o,
    input  vrf_rdata_i,
    output vrf_we_o, vrf_waddr_o, vrf_wdata_o
  );

  modport slave (
    input  lsu_req_o, lsu_we_o, lsu_addr_o, lsu_wdata_o,
    output lsu_gnt_i, lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    input  vrf_raddr_o,
    output vrf_rdata_i,
    input  vrf_we_o, vrf_waddr_o, vrf_wdata_o
  );
endinterface

// File: rtl/vcve2_vlsu_sequencer.sv
// rtl/vcve2_vlsu_sequencer.sv - walks vl vector elements, one outstanding LSU access at a time
module vcve2_vlsu_sequencer #(
  parameter int MAX_VL = 32,
  parameter int CNT_W  = $clog2(MAX_VL) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 is_store_i,
  input  logic                 unit_stride_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [CNT_W-1:0]     vl_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  vcve2_vlsu_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FIN
  } state_e;

  localparam logic [CNT_W-2:0] IdxOne = 1;
  localparam logic [CNT_W-1:0] VlOne  = 1;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      stride_q, stride_d;
  logic [CNT_W-2:0] idx_q, idx_d;
  logic [CNT_W-1:0] vl_q, vl_d;
  logic             store_q, store_d;
  logic             err_q, err_d;
  logic             last_elem;

  assign last_elem = ({1'b0, idx_q} == (vl_q - VlOne));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    idx_d    = idx_q;
    vl_d     = vl_q;
    store_d  = store_q;
    err_d    = err_q;

    busy_o           = (state_q != S_IDLE);
    done_o           = 1'b0;
    err_o            = 1'b0;
    bus.lsu_req_o    = 1'b0;
    bus.lsu_we_o     = 1'b0;
    bus.lsu_addr_o   = '0;
    bus.lsu_wdata_o  = '0;
    bus.vrf_raddr_o  = '0;
    bus.vrf_we_o     = 1'b0;
    bus.vrf_waddr_o  = '0;
    bus.vrf_wdata_o  = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // Unit stride is folded into the stride register at capture time.
          stride_d = unit_stride_i ? 32'd4 : stride_i;
          store_d  = is_store_i;
          vl_d     = vl_i;
          addr_d   = base_addr_i;
          idx_d    = '0;
          err_d    = 1'b0;
          state_d  = (vl_i != '0) ? S_REQ : S_FIN;
        end
      end

      S_REQ: begin
        bus.lsu_req_o   = 1'b1;
        bus.lsu_we_o    = store_q;
        bus.lsu_addr_o  = addr_q;
        bus.lsu_wdata_o = bus.vrf_rdata_i;
        bus.vrf_raddr_o = idx_q;
        if (bus.lsu_gnt_i) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.lsu_rvalid_i) begin
          if (bus.lsu_err_i) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            bus.vrf_we_o    = !store_q;
            bus.vrf_waddr_o = store_q ? '0 : idx_q;
            bus.vrf_wdata_o = store_q ? '0 : bus.lsu_rdata_i;
            if (last_elem) begin
              state_d = S_FIN;
            end else begin
              idx_d   = idx_q + IdxOne;
              addr_d  = addr_q + stride_q;
              state_d = S_REQ;
            end
          end
        end
      end

      S_FIN: begin
        done_o  = 1'b1;
        err_o   = err_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      idx_q    <= '0;
      vl_q     <= '0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      idx_q    <= idx_d;
      vl_q     <= vl_d;
      store_q  <= store_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_vcve2_vlsu_sequencer.sv
// tb/tb_vcve2_vlsu_sequencer.sv - scoreboard bench for the vector LSU sequencer
module tb_vcve2_vlsu_sequencer;
  localparam int MAX_VL = 32;
  localparam int CNT_W  = 6;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic             is_store_i = 1'b0;
  logic             unit_stride_i = 1'b0;
  logic [31:0]      base_addr_i = '0;
  logic [31:0]      stride_i = '0;
  logic [CNT_W-1:0] vl_i = '0;
  logic             busy_o, done_o, err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] vrf_mem [MAX_VL];

  logic [31:0] exp_addr_q [$];
  logic        exp_we_q [$];
  logic [31:0] exp_wdata_q [$];
  int          exp_widx_q [$];
  logic [31:0] exp_wval_q [$];

  vcve2_vlsu_sequencer_if #(.CNT_W(CNT_W)) bus ();

  vcve2_vlsu_sequencer #(.MAX_VL(MAX_VL), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .is_store_i    (is_store_i),
    .unit_stride_i (unit_stride_i),
    .base_addr_i   (base_addr_i),
    .stride_i      (stride_i),
    .vl_i          (vl_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .bus           (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  assign bus.vrf_rdata_i = vrf_mem[bus.vrf_raddr_o];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input int op, input int i);
    return 32'hA500_0000 + op * 32'h0001_0000 + i * 32'h0000_0101;
  endfunction

  task automatic run_op(input int op, input logic st, input logic unit, input logic [31:0] base,
                        input logic [31:0] stride, input int vl, input int gnt_dly,
                        input int err_elem, input bit poke_start);
    logic [31:0] step, a, hold_addr, hold_wdata;
    int n_issue, start_cyc, last_rv_cyc, waitc, resp_idx, n_gnt;
    bit pending, have_hold, fin, err_exp;
    step    = unit ? 32'd4 : stride;
    err_exp = (err_elem >= 0) && (err_elem < vl);
    n_issue = err_exp ? err_elem + 1 : vl;
    a = base;
    for (int i = 0; i < n_issue; i++) begin
      exp_addr_q.push_back(a);
      exp_we_q.push_back(st);
      exp_wdata_q.push_back(vrf_mem[i]);
      if (!st && i != err_elem) begin
        exp_widx_q.push_back(i);
        exp_wval_q.push_back(rdata_of(op, i));
      end
      a = a + step;
    end

    @(posedge clk_i); #1;
    start_i = 1'b1; is_store_i = st; unit_stride_i = unit;
    base_addr_i = base; stride_i = stride; vl_i = CNT_W'(vl);
    start_cyc = cyc;
    last_rv_cyc = -10; waitc = 0; resp_idx = 0; n_gnt = 0;
    pending = 0; have_hold = 0; fin = 0;

    for (int t = 0; t < 600 && !fin; t++) begin
      @(posedge clk_i); #1;
      start_i = poke_start && (t < 4);
      if (poke_start) begin
        base_addr_i = 32'hDEAD_0000; vl_i = CNT_W'(1); is_store_i = !st;
      end
      bus.lsu_rvalid_i = pending;
      bus.lsu_err_i    = pending && (resp_idx == err_elem);
      bus.lsu_rdata_i  = pending ? rdata_of(op, resp_idx) : $urandom;
      if (pending) last_rv_cyc = cyc;
      bus.lsu_gnt_i = bus.lsu_req_o && (waitc >= gnt_dly);
      #1;
      check_eq("busy_in_op", busy_o, 1);
      if (bus.vrf_we_o) begin
        if (exp_widx_q.size() == 0) check_eq("vrf_we_unexpected", 1, 0);
        else begin
          check_eq("vrf_waddr", bus.vrf_waddr_o, exp_widx_q.pop_front());
          check_eq("vrf_wdata", bus.vrf_wdata_o, exp_wval_q.pop_front());
        end
      end
      if (pending) begin
        pending = 0;
        resp_idx++;
      end
      if (bus.lsu_req_o) begin
        if (have_hold) begin
          check_eq("hold_addr", bus.lsu_addr_o, hold_addr);
          check_eq("hold_wdata", bus.lsu_wdata_o, hold_wdata);
        end
        if (bus.lsu_gnt_i) begin
          n_gnt++;
          if (exp_addr_q.size() == 0) check_eq("req_unexpected", 1, 0);
          else begin
            check_eq("lsu_addr", bus.lsu_addr_o, exp_addr_q.pop_front());
            check_eq("lsu_we", bus.lsu_we_o, exp_we_q.pop_front());
            if (st) check_eq("lsu_wdata", bus.lsu_wdata_o, exp_wdata_q.pop_front());
            else void'(exp_wdata_q.pop_front());
          end
          pending = 1; have_hold = 0; waitc = 0;
        end else begin
          have_hold = 1; hold_addr = bus.lsu_addr_o; hold_wdata = bus.lsu_wdata_o;
          waitc++;
        end
      end
      if (done_o) begin
        check_eq("err_o", err_o, err_exp);
        check_eq("done_latency", cyc, (vl == 0) ? start_cyc + 1 : last_rv_cyc + 1);
        fin = 1;
      end
    end
    bus.lsu_rvalid_i = 0; bus.lsu_err_i = 0; bus.lsu_gnt_i = 0; start_i = 0;
    if (!fin) check_eq("done_timeout", 0, 1);
    check_eq("n_requests", n_gnt, n_issue);
    check_eq("req_left", exp_addr_q.size(), 0);
    check_eq("vrf_wr_left", exp_widx_q.size(), 0);
    exp_addr_q.delete(); exp_we_q.delete(); exp_wdata_q.delete();
    exp_widx_q.delete(); exp_wval_q.delete();
    @(posedge clk_i); #2;
    check_eq("done_single", done_o, 0);
    check_eq("idle_busy", busy_o, 0);
    check_eq("idle_req", bus.lsu_req_o, 0);
  endtask

  initial begin
    for (int i = 0; i < MAX_VL; i++) vrf_mem[i] = 32'hC0DE_0000 + i * 32'h0000_1357;
    bus.lsu_gnt_i = 0; bus.lsu_rvalid_i = 0; bus.lsu_rdata_i = '0; bus.lsu_err_i = 0;

    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_req", bus.lsu_req_o, 0);
    check_eq("rst_addr", bus.lsu_addr_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_eq("post_rst_vrf_we", bus.vrf_we_o, 0);
    check_eq("post_rst_err", err_o, 0);

    run_op(1, 1'b0, 1'b1, 32'h0000_1000, 32'h0,        4,  0, -1, 0);
    run_op(2, 1'b1, 1'b0, 32'h0000_2000, 32'hFFFF_FFF8, 3, 0, -1, 0);
    run_op(3, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_0040, 3, 5, -1, 0);
    run_op(4, 1'b0, 1'b1, 32'h0000_5000, 32'h0,        4,  1,  1, 0);
    run_op(5, 1'b0, 1'b1, 32'h0000_6000, 32'h0,        0,  0, -1, 0);
    run_op(6, 1'b1, 1'b1, 32'h0000_7000, 32'h0,        3,  0, -1, 1);
    run_op(7, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,        2,  0, -1, 0);
    run_op(8, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_000C, MAX_VL, 2, -1, 0);
    run_op(9, 1'b0, 1'b0, 32'h0000_8000, 32'hFFFF_FFF0, 5, 1, 4, 0);

    // Asynchronous reset while an element is outstanding.
    @(posedge clk_i); #1;
    start_i = 1; is_store_i = 0; unit_stride_i = 1; base_addr_i = 32'h3000; vl_i = CNT_W'(4);
    @(posedge clk_i); #1;
    start_i = 0; bus.lsu_gnt_i = 1;
    #1;
    check_eq("rstw_req", bus.lsu_req_o, 1);
    @(posedge clk_i); #1;
    bus.lsu_gnt_i = 0;
    #1;
    check_eq("rstw_wait_req", bus.lsu_req_o, 0);
    check_eq("rstw_wait_busy", busy_o, 1);
    rst_ni = 0;
    #1;
    check_eq("rstw_busy", busy_o, 0);
    check_eq("rstw_done", done_o, 0);
    check_eq("rstw_vrf_we", bus.vrf_we_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    bus.lsu_rvalid_i = 1; bus.lsu_rdata_i = 32'h1234_5678;
    #1;
    check_eq("rstw_drop_resp", bus.vrf_we_o, 0);
    @(posedge clk_i); #1;
    bus.lsu_rvalid_i = 0;
    #1;
    check_eq("rstw_idle_busy", busy_o, 0);
    check_eq("rstw_idle_req", bus.lsu_req_o, 0);
    check_eq("rstw_idle_done", done_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=0", cyc);
    $fatal(1);
  end
endmodule
